// File: rtl/enigma_rotor_stepper.sv
// Rotor stepping front stage: accepts a key symbol, advances the three rotor
// positions with odometer and double-step rules, and emits the offset symbol.
module enigma_rotor_stepper #(
    parameter int NUM_SYM = 26,
    parameter int NOTCH1  = 16,
    parameter int NOTCH2  = 4,
    parameter int NOTCH3  = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [4:0] load_pos1,
    input  logic [4:0] load_pos2,
    input  logic [4:0] load_pos3,
    input  logic       key_valid,
    input  logic [4:0] key_sym,
    output logic       key_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_sym,
    output logic [4:0] pos1,
    output logic [4:0] pos2,
    output logic [4:0] pos3,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, STEP, OUT} state_t;

    localparam logic [5:0] NUM6 = 6'(NUM_SYM);
    localparam logic [4:0] N1   = 5'(NOTCH1);
    localparam logic [4:0] N2   = 5'(NOTCH2);

    // The rotor-3 notch never causes stepping; it is only range-checked here.
    if (NOTCH1 >= NUM_SYM || NOTCH2 >= NUM_SYM || NOTCH3 >= NUM_SYM) begin : g_bad_notch
        $error("enigma_rotor_stepper: notch position outside the alphabet");
    end

    state_t     state, state_nxt;
    logic [4:0] key_q;
    logic       key_ok;
    logic       accept;
    logic [4:0] pos1_new;

    function automatic logic [4:0] clamp_sym(input logic [4:0] s);
        return ({1'b0, s} >= NUM6) ? 5'd0 : s;
    endfunction

    function automatic logic [4:0] inc_wrap(input logic [4:0] p);
        return (({1'b0, p} + 6'd1) >= NUM6) ? 5'd0 : (p + 5'd1);
    endfunction

    function automatic logic [4:0] add_mod(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= NUM6) s = s - NUM6;
        return s[4:0];
    endfunction

    assign key_ready = (state == IDLE) && !load;
    assign accept    = key_valid && key_ready;
    assign key_ok    = {1'b0, key_sym} < NUM6;
    assign pos1_new  = inc_wrap(pos1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && key_ok) state_nxt = STEP;
            STEP:    state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Captured key is pure data; it is only consumed in STEP after a capture.
    always_ff @(posedge clk) begin
        if (state == IDLE && accept && key_ok) key_q <= key_sym;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos1      <= 5'd0;
            pos2      <= 5'd0;
            pos3      <= 5'd0;
            out_valid <= 1'b0;
            out_sym   <= 5'd0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        pos1 <= clamp_sym(load_pos1);
                        pos2 <= clamp_sym(load_pos2);
                        pos3 <= clamp_sym(load_pos3);
                    end else if (accept && !key_ok) begin
                        err <= 1'b1;
                    end
                end
                STEP: begin
                    // Rotor 2 also steps on its own notch: the double step.
                    pos1 <= pos1_new;
                    if (pos1 == N1 || pos2 == N2) pos2 <= inc_wrap(pos2);
                    if (pos2 == N2) pos3 <= inc_wrap(pos3);
                    out_sym   <= add_mod(key_q, pos1_new);
                    out_valid <= 1'b1;
                end
                OUT: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_enigma_rotor_stepper.sv
// Directed bench for enigma_rotor_stepper: stepping, wrap, backpressure,
// invalid keys, load priority and asynchronous reset abort.
module tb_enigma_rotor_stepper;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [4:0] load_pos1, load_pos2, load_pos3;
    logic       key_valid;
    logic [4:0] key_sym;
    logic       key_ready;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_sym;
    logic [4:0] pos1, pos2, pos3;
    logic       err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    enigma_rotor_stepper dut (
        .clk(clk), .rst(rst), .load(load),
        .load_pos1(load_pos1), .load_pos2(load_pos2), .load_pos3(load_pos3),
        .key_valid(key_valid), .key_sym(key_sym), .key_ready(key_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
        .pos1(pos1), .pos2(pos2), .pos3(pos3), .err(err)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic do_load(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        @(negedge clk);
        load = 1'b1; load_pos1 = a; load_pos2 = b; load_pos3 = c;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Leaves the bench at the negedge where out_valid should first be high.
    task automatic offer_key(input logic [4:0] s);
        @(negedge clk);
        key_valid = 1'b1; key_sym = s;
        @(negedge clk);
        key_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; load_pos1 = '0; load_pos2 = '0; load_pos3 = '0;
        key_valid = 1'b0; key_sym = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (key_ready !== 1'b1) $display("FAIL reset_key_ready got %b want 1", key_ready); else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0 || out_sym !== 5'd0 || err !== 1'b0)
            $display("FAIL reset_outputs got v=%b sym=%0d err=%b want 0/0/0", out_valid, out_sym, err);
        else n_pass++;
        n_checks++;
        if ({pos1, pos2, pos3} !== 15'd0)
            $display("FAIL reset_pos got (%0d,%0d,%0d) want (0,0,0)", pos1, pos2, pos3);
        else n_pass++;
    endtask

    task automatic test_basic_step();
        @(negedge clk);
        key_valid = 1'b1; key_sym = 5'd0;
        @(negedge clk);
        key_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL basic_latency out_valid got %b want 0", out_valid); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_sym !== 5'd1)
            $display("FAIL basic_out got v=%b sym=%0d want 1/1", out_valid, out_sym);
        else n_pass++;
        n_checks++;
        if (pos1 !== 5'd1 || pos2 !== 5'd0 || pos3 !== 5'd0)
            $display("FAIL basic_pos got (%0d,%0d,%0d) want (1,0,0)", pos1, pos2, pos3);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || key_ready !== 1'b1)
            $display("FAIL basic_done got v=%b rdy=%b want 0/1", out_valid, key_ready);
        else n_pass++;
    endtask

    task automatic test_double_step();
        @(negedge clk);
        load = 1'b1; load_pos1 = 5'd16; load_pos2 = 5'd3; load_pos3 = 5'd0;
        #1;
        n_checks++;
        if (key_ready !== 1'b0) $display("FAIL load_blocks_ready got %b want 0", key_ready); else n_pass++;
        @(negedge clk);
        load = 1'b0;
        n_checks++;
        if (pos1 !== 5'd16 || pos2 !== 5'd3 || pos3 !== 5'd0)
            $display("FAIL load_pos got (%0d,%0d,%0d) want (16,3,0)", pos1, pos2, pos3);
        else n_pass++;
        offer_key(5'd0);
        n_checks++;
        if (pos1 !== 5'd17 || pos2 !== 5'd4 || pos3 !== 5'd0 || out_sym !== 5'd17)
            $display("FAIL turnover got (%0d,%0d,%0d) sym=%0d want (17,4,0) sym=17", pos1, pos2, pos3, out_sym);
        else n_pass++;
        offer_key(5'd0);
        n_checks++;
        if (pos1 !== 5'd18 || pos2 !== 5'd5 || pos3 !== 5'd1 || out_sym !== 5'd18)
            $display("FAIL double_step got (%0d,%0d,%0d) sym=%0d want (18,5,1) sym=18", pos1, pos2, pos3, out_sym);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_load(5'd24, 5'd0, 5'd0);
        offer_key(5'd3);
        n_checks++;
        if (pos1 !== 5'd25 || out_sym !== 5'd2)
            $display("FAIL sum_wrap got pos1=%0d sym=%0d want 25/2", pos1, out_sym);
        else n_pass++;
        offer_key(5'd25);
        n_checks++;
        if (pos1 !== 5'd0 || pos2 !== 5'd0 || out_sym !== 5'd25)
            $display("FAIL pos_wrap got pos1=%0d pos2=%0d sym=%0d want 0/0/25", pos1, pos2, out_sym);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int bad = 0;
        @(negedge clk);
        out_ready = 1'b0;
        key_valid = 1'b1; key_sym = 5'd5;
        @(negedge clk);
        key_sym = 5'd7;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || out_sym !== 5'd6 || key_ready !== 1'b0 || pos1 !== 5'd1 || pos2 !== 5'd0)
                bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad != 0)
            $display("FAIL backpressure_hold got %0d bad cycles (v=%b sym=%0d rdy=%b pos1=%0d) want 0",
                     bad, out_valid, out_sym, key_ready, pos1);
        else n_pass++;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || key_ready !== 1'b1)
            $display("FAIL backpressure_release got v=%b rdy=%b want 0/1", out_valid, key_ready);
        else n_pass++;
        @(negedge clk);
        key_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_sym !== 5'd9 || pos1 !== 5'd2)
            $display("FAIL second_key got v=%b sym=%0d pos1=%0d want 1/9/2", out_valid, out_sym, pos1);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_invalid_key();
        @(negedge clk);
        key_valid = 1'b1; key_sym = 5'd27;
        @(negedge clk);
        key_valid = 1'b0;
        n_checks++;
        if (err !== 1'b1 || out_valid !== 1'b0 || pos1 !== 5'd2 || key_ready !== 1'b1)
            $display("FAIL invalid_err got err=%b v=%b pos1=%0d rdy=%b want 1/0/2/1", err, out_valid, pos1, key_ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0 || out_valid !== 1'b0 || pos1 !== 5'd2)
            $display("FAIL invalid_after got err=%b v=%b pos1=%0d want 0/0/2", err, out_valid, pos1);
        else n_pass++;
        load = 1'b1; load_pos1 = 5'd30; load_pos2 = 5'd1; load_pos3 = 5'd2;
        key_valid = 1'b1; key_sym = 5'd27;
        #1;
        n_checks++;
        if (key_ready !== 1'b0) $display("FAIL load_priority_ready got %b want 0", key_ready); else n_pass++;
        @(negedge clk);
        load = 1'b0; key_valid = 1'b0;
        n_checks++;
        if (err !== 1'b0 || pos1 !== 5'd0 || pos2 !== 5'd1 || pos3 !== 5'd2)
            $display("FAIL load_clamp got err=%b (%0d,%0d,%0d) want 0 (0,1,2)", err, pos1, pos2, pos3);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        key_valid = 1'b1; key_sym = 5'd1;
        @(negedge clk);
        key_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (pos2 !== 5'd0 || pos3 !== 5'd0 || out_valid !== 1'b0)
            $display("FAIL rst_step_async got pos2=%0d pos3=%0d v=%b want 0/0/0", pos2, pos3, out_valid);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || pos1 !== 5'd0)
            $display("FAIL rst_step_no_out got v=%b pos1=%0d want 0/0", out_valid, pos1);
        else n_pass++;
        out_ready = 1'b0;
        offer_key(5'd2);
        n_checks++;
        if (out_valid !== 1'b1 || out_sym !== 5'd3)
            $display("FAIL rst_out_setup got v=%b sym=%0d want 1/3", out_valid, out_sym);
        else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_sym !== 5'd0 || pos1 !== 5'd0 || key_ready !== 1'b1)
            $display("FAIL rst_out_async got v=%b sym=%0d pos1=%0d rdy=%b want 0/0/0/1",
                     out_valid, out_sym, pos1, key_ready);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || err !== 1'b0)
            $display("FAIL rst_out_no_out got v=%b err=%b want 0/0", out_valid, err);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_step();
        test_double_step();
        test_wrap();
        test_backpressure();
        test_invalid_key();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/enigma_rotor_stepper.md
# enigma_rotor_stepper

Sequential front stage of the rotor path: accepts one 5-bit key symbol per handshake, advances the three rotor positions with Enigma odometer and double-step rules, and presents the position-offset symbol to the combinational rotor-wiring stage downstream. Symbols are encoded 0..25 (A..Z). Exported positions feed the later stages that remove the rotor offset.

## Interface
Parameters:
- NUM_SYM, 26, symbol alphabet size; all arithmetic is modulo NUM_SYM.
- NOTCH1, 16, rotor-1 turnover position (Q).
- NOTCH2, 4, rotor-2 turnover position (E).
- NOTCH3, 21, rotor-3 notch (V). Stored only; it does not trigger any stepping.

Ports:
- clk  in  1  single clock for the whole block; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  loads the start positions. Sampled in IDLE only.
- load_pos1, load_pos2, load_pos3  in  5 each  start positions. A value ≥26 is stored as 0.
- key_valid  in  1  key symbol offered.
- key_sym  in  5  key symbol.
- key_ready  out  1  combinational: state==IDLE && !load.
- out_valid  out  1  offset symbol valid (registered).
- out_ready  in  1  downstream accepts.
- out_sym  out  5  (key_sym + pos1_new) mod 26, driven to the wiring stage input x[5:1].
- pos1, pos2, pos3  out  5 each  current rotor positions (registered).
- err  out  1  one-cycle pulse on an invalid key.

## Operation
- FSM states: IDLE, STEP, OUT.
- **IDLE**
  - load=1: write the three positions (with clamping) at the edge. Load wins over key_valid.
  - key_valid && key_ready with key_sym<26: capture key_sym, go to STEP.
  - key_valid && key_ready with key_sym≥26: consume the key and pulse err for one cycle. No step, no output, stay in IDLE.
- **STEP** (one cycle), using pre-step values p1, p2:
  - pos1 ← p1+1.
  - pos2 ← p2+1 if p1==NOTCH1 or p2==NOTCH2. The p2==NOTCH2 term is the double step.
  - pos3 ← pos3+1 if p2==NOTCH2.
  - Each increment wraps 25→0.
  - out_sym ← (key + new pos1): form a 6-bit sum and subtract 26 if the sum is ≥26.
  - Set out_valid. Go to OUT.
- **OUT**
  - Hold out_valid, out_sym and the positions stable until out_valid && out_ready.
  - At that edge, clear out_valid and return to IDLE.
- load and key_valid are ignored outside IDLE. key_ready is 0 there.
- rst asserted in any state forces the reset values immediately and aborts the in-flight symbol. Nothing partial is emitted.

## Timing
- Reset values:
  - state IDLE, so key_ready=1 when load=0.
  - out_valid=0, out_sym=0.
  - pos1=pos2=pos3=0.
  - err=0.
- Key accepted at edge N.
  - Positions and out_sym update at edge N+1.
  - out_valid is high from edge N+1.
- With out_ready tied high:
  - out_valid is high for exactly one cycle.
  - IDLE is re-entered at edge N+2; key_ready is high in the following cycle.
  - Peak throughput is one symbol per 3 cycles.
- Load takes effect at the edge where it is sampled. Positions are visible on pos* the next cycle.
- err rises at the edge that accepts the invalid key and falls one cycle later.
- Positions change only at the STEP edge or the load edge, never in OUT.

## Test plan
- Reset, then key_sym=0 → pos=(1,0,0), out_sym=1, out_valid one cycle after acceptance.
- Load (16,3,0), key_sym=0 → pos=(17,4,0). Next key_sym=0 → pos=(18,5,1), out_sym=18. This covers notch turnover plus the double step.
- Load (24,0,0), key_sym=3 → pos1=25, out_sym=2. Next key_sym=25 → pos1=0, out_sym=25. This covers wrap in both the position and the sum.
- Backpressure: out_ready=0 for 5 cycles with a second key_valid held → out_valid and out_sym stable, key_ready=0, positions unchanged. out_ready=1 → handshake completes, then the second key is accepted the next IDLE cycle.
- key_sym=27 → err is high for one cycle, positions unchanged, no out_valid. Same cycle with load=1 and load_pos1=30 → load wins, pos1=0, key not consumed.
- rst pulsed while in STEP and again while in OUT → all outputs return to reset values asynchronously, and no out_valid follows.
